// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Five independent push-button conditioning channels (H, M, L, G, A). Each raw
// asynchronous input is synchronized through two flops and then debounced: a
// new level is accepted only after DEB_CYCLES consecutive synchronized samples
// disagree with the current debounced level. Every accepted change, rising or
// falling, produces a single-cycle pulse on that channel's pulse output.
//
// Parameters:
//   DEB_CYCLES  consecutive mismatching samples needed to accept a new level
//               (legal range 1..65535)
//
// Ports:
//   CLK                 system clock, all state updates on the rising edge
//   RST                 asynchronous, active-high reset
//   H, M, L, G, A       raw, bouncing button levels (asynchronous)
//   HD, MD, LD, GD, AD  debounced levels, registered
//   PH, PM, PL, PG, PA  one-cycle change pulses, registered
//   P                   combinational OR of the five pulse registers
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int unsigned DEB_CYCLES = 4
) (
    input  logic CLK,
    input  logic RST,

    input  logic H,
    input  logic M,
    input  logic L,
    input  logic G,
    input  logic A,

    output logic HD,
    output logic MD,
    output logic LD,
    output logic GD,
    output logic AD,

    output logic PH,
    output logic PM,
    output logic PL,
    output logic PG,
    output logic PA,

    output logic P
);

    localparam int unsigned NumCh   = 5;
    localparam int unsigned CntW    = 16;
    localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

    // Channel index: 0=H, 1=M, 2=L, 3=G, 4=A.
    logic [NumCh-1:0] raw;

    logic [NumCh-1:0] s1_q;
    logic [NumCh-1:0] s2_q;
    logic [NumCh-1:0] db_q;
    logic [NumCh-1:0] db_d;
    logic [NumCh-1:0] pulse_q;
    logic [NumCh-1:0] pulse_d;
    logic [CntW-1:0]  cnt_q [NumCh];
    logic [CntW-1:0]  cnt_d [NumCh];

    assign raw = {A, G, L, M, H};

    // -------------------------------------------------------------------------
    // Two-flop synchronizers. Nothing downstream looks at raw or s1_q.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Debounce next-state. Any sample that agrees with the debounced level
    // restarts the count, so a bounce can never accumulate toward a change.
    // The terminal test uses >= so an out-of-range count can only ever resolve
    // back to zero rather than climb and wrap.
    // -------------------------------------------------------------------------
    always_comb begin
        db_d    = db_q;
        pulse_d = '0;
        for (int i = 0; i < NumCh; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= CntLast) begin
                db_d[i]    = s2_q[i];
                cnt_d[i]   = '0;
                pulse_d[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Debounce state. Reset zeroes the debounced levels without pulsing, so a
    // button held through reset is seen afterwards as a fresh press.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            db_q    <= '0;
            pulse_q <= '0;
            for (int i = 0; i < NumCh; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q    <= db_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < NumCh; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs straight from registers; P is a plain OR with no extra stage.
    // -------------------------------------------------------------------------
    assign HD = db_q[0];
    assign MD = db_q[1];
    assign LD = db_q[2];
    assign GD = db_q[3];
    assign AD = db_q[4];

    assign PH = pulse_q[0];
    assign PM = pulse_q[1];
    assign PL = pulse_q[2];
    assign PG = pulse_q[3];
    assign PA = pulse_q[4];

    assign P = |pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed bench for button_conditioner with DEB_CYCLES=4. Inputs change just
// after a rising edge; outputs are sampled 1 time unit after each rising edge.
// Observed output vector layout: {P, PA,PG,PL,PM,PH, AD,GD,LD,MD,HD}.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int unsigned Deb = 4;

    logic CLK;
    logic RST;
    logic H, M, L, G, A;
    logic HD, MD, LD, GD, AD;
    logic PH, PM, PL, PG, PA;
    logic P;

    logic [10:0] outs;

    int checks;
    int failures;

    button_conditioner #(
        .DEB_CYCLES(Deb)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .H  (H),
        .M  (M),
        .L  (L),
        .G  (G),
        .A  (A),
        .HD (HD),
        .MD (MD),
        .LD (LD),
        .GD (GD),
        .AD (AD),
        .PH (PH),
        .PM (PM),
        .PL (PL),
        .PG (PG),
        .PA (PA),
        .P  (P)
    );

    assign outs = {P, PA, PG, PL, PM, PH, AD, GD, LD, MD, HD};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // db / pl bit order: 0=H, 1=M, 2=L, 3=G, 4=A
    function automatic logic [10:0] ev(input logic [4:0] db, input logic [4:0] pl);
        return {|pl, pl, db};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [10:0] exp);
        checks++;
        assert (outs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, outs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RST = 1'b1;
        H = 1'b0; M = 1'b0; L = 1'b0; G = 1'b0; A = 1'b0;

        // Reset state
        #1;
        chk("reset_t0", ev(5'b00000, 5'b00000));
        step();
        step();
        chk("reset_clocked", ev(5'b00000, 5'b00000));
        RST = 1'b0;
        step();
        chk("post_reset_idle", ev(5'b00000, 5'b00000));

        // Clean press on H: pulse after edge k+5
        H = 1'b1;
        for (int e = 0; e < Deb + 1; e++) begin
            step();
            chk($sformatf("press_wait_e%0d", e), ev(5'b00000, 5'b00000));
        end
        step();
        chk("press_pulse", ev(5'b00001, 5'b00001));
        step();
        chk("press_after", ev(5'b00001, 5'b00000));

        // Release H so it can be bounced again
        H = 1'b0;
        for (int e = 0; e < Deb + 1; e++) step();
        chk("h_release_wait", ev(5'b00001, 5'b00000));
        step();
        chk("h_release_pulse", ev(5'b00000, 5'b00001));
        step();
        chk("h_release_after", ev(5'b00000, 5'b00000));

        // Bounce 1,0,1,0 then hold 1 from before edge k
        H = 1'b1; step(); chk("bounce_b1", ev(5'b00000, 5'b00000));
        H = 1'b0; step(); chk("bounce_b2", ev(5'b00000, 5'b00000));
        H = 1'b1; step(); chk("bounce_b3", ev(5'b00000, 5'b00000));
        H = 1'b0; step(); chk("bounce_b4", ev(5'b00000, 5'b00000));
        H = 1'b1;
        for (int e = 0; e < Deb + 1; e++) begin
            step();
            chk($sformatf("bounce_hold_e%0d", e), ev(5'b00000, 5'b00000));
        end
        step();
        chk("bounce_pulse", ev(5'b00001, 5'b00001));
        step();
        chk("bounce_after", ev(5'b00001, 5'b00000));

        // Two-cycle glitch on G: no change, no pulse
        G = 1'b1;
        step();
        step();
        G = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            chk($sformatf("glitch_e%0d", e), ev(5'b00001, 5'b00000));
        end

        // M and A rise together
        M = 1'b1;
        A = 1'b1;
        for (int e = 0; e < Deb + 1; e++) step();
        chk("simul_wait", ev(5'b00001, 5'b00000));
        step();
        chk("simul_pulse", ev(5'b10011, 5'b10010));
        step();
        chk("simul_after", ev(5'b10011, 5'b00000));

        // Bring L high, then release it
        L = 1'b1;
        for (int e = 0; e < Deb + 1; e++) step();
        step();
        chk("l_press_pulse", ev(5'b10111, 5'b00100));
        step();
        chk("l_press_after", ev(5'b10111, 5'b00000));
        L = 1'b0;
        for (int e = 0; e < Deb + 1; e++) begin
            step();
            chk($sformatf("l_release_wait_e%0d", e), ev(5'b10111, 5'b00000));
        end
        step();
        chk("l_release_pulse", ev(5'b10011, 5'b00100));
        step();
        chk("l_release_after", ev(5'b10011, 5'b00000));

        // Release H, M, A together: three falling pulses in one cycle
        H = 1'b0;
        M = 1'b0;
        A = 1'b0;
        for (int e = 0; e < Deb + 1; e++) step();
        chk("multi_fall_wait", ev(5'b10011, 5'b00000));
        step();
        chk("multi_fall_pulse", ev(5'b00000, 5'b10011));
        step();
        chk("multi_fall_after", ev(5'b00000, 5'b00000));

        // Reset mid-count: H rises, RST asserted two edges later, H held
        H = 1'b1;
        step();
        step();
        chk("midcount_pre_rst", ev(5'b00000, 5'b00000));
        RST = 1'b1;
        #1;
        chk("midcount_rst_async", ev(5'b00000, 5'b00000));
        step();
        chk("midcount_rst_e0", ev(5'b00000, 5'b00000));
        step();
        chk("midcount_rst_e1", ev(5'b00000, 5'b00000));
        RST = 1'b0;
        // First post-reset edge is f; pulse due after edge f+Deb+1
        for (int e = 0; e < Deb + 1; e++) begin
            step();
            chk($sformatf("midcount_post_e%0d", e), ev(5'b00000, 5'b00000));
        end
        step();
        chk("midcount_pulse", ev(5'b00001, 5'b00001));
        step();
        chk("midcount_after", ev(5'b00001, 5'b00000));
        step();
        chk("midcount_after2", ev(5'b00001, 5'b00000));

        // Async reset with a debounced level high clears it without a clock
        #2;
        RST = 1'b1;
        #1;
        chk("async_clear", ev(5'b00000, 5'b00000));
        RST = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
